rf_writeback_arbiter: RTL and testbench

- Shares one physical register file write port among NUM_UNITS writeback requesters.
- Requesters are functional units such as multi-cycle units or the load/store unit. Each one completes on a single port of the register file.
- Arbitration is round-robin with a registered commit stage.
- The registered commit output drives the register bank write (commit valid, phys addr, data) and the inflight-clear toggle for that port.

---
 rtl/rf_writeback_arbiter.sv | 74 +++++++
 tb/tb_rf_writeback_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: round-robin share of one register-file write port with a registered commit stage
module rf_writeback_arbiter #(
    parameter int NUM_UNITS      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int PHYS_ADDR_W    = 6,
    parameter bit ALLOW_WRITE_P0 = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_UNITS-1:0]              unit_valid,
    input  logic [NUM_UNITS*PHYS_ADDR_W-1:0]  unit_phys_addr,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0]   unit_data,
    output logic [NUM_UNITS-1:0]              unit_ack,
    input  logic                              writeback_suppress,
    output logic                              commit_valid,
    output logic [PHYS_ADDR_W-1:0]            commit_phys_addr,
    output logic [DATA_WIDTH-1:0]             commit_data,
    output logic [(NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1)-1:0] commit_unit
);
    localparam int UW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;

    logic [UW-1:0]          rr_ptr;
    logic [UW-1:0]          grant_idx;
    logic [UW-1:0]          cand;
    logic [UW-1:0]          rr_next;
    logic                   grant_any;
    logic [PHYS_ADDR_W-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]  sel_data;

    // first valid unit at or after rr_ptr wins; suppress and reset block every grant
    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        unit_ack  = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = UW'((int'(rr_ptr) + k) % NUM_UNITS);
            if (!grant_any && unit_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        grant_any = grant_any && !writeback_suppress && !rst;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (grant_idx == UW'(k)) begin
                unit_ack[k] = grant_any;
                sel_addr    = unit_phys_addr[k*PHYS_ADDR_W +: PHYS_ADDR_W];
                sel_data    = unit_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        rr_next = (grant_idx == UW'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
    end

    // register the granted write; addr 0 is consumed but not written unless allowed
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid     <= 1'b0;
            commit_phys_addr <= '0;
            commit_data      <= '0;
            commit_unit      <= '0;
            rr_ptr           <= '0;
        end else begin
            commit_valid <= grant_any && (ALLOW_WRITE_P0 || sel_addr != '0);
            if (grant_any) begin
                commit_phys_addr <= sel_addr;
                commit_data      <= sel_data;
                commit_unit      <= grant_idx;
                rr_ptr           <= rr_next;
            end
        end
    end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed scoreboard bench for the writeback arbiter
module tb_rf_writeback_arbiter;
    typedef struct packed {
        logic        v;
        logic [5:0]  a;
        logic [31:0] d;
        logic [1:0]  u;
    } commit_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  unit_valid = '0;
    logic [23:0] unit_phys_addr;
    logic [127:0] unit_data;
    logic [3:0]  unit_ack;
    logic        writeback_suppress = 1'b0;
    logic        commit_valid;
    logic [5:0]  commit_phys_addr;
    logic [31:0] commit_data;
    logic [1:0]  commit_unit;

    logic [5:0]  addr_a [4];
    logic [31:0] data_a [4];
    commit_t     sb [$];
    commit_t     m_hold = '0;
    int          tests = 0;
    int          fails = 0;

    rf_writeback_arbiter dut (
        .clk(clk), .rst(rst), .unit_valid(unit_valid), .unit_phys_addr(unit_phys_addr),
        .unit_data(unit_data), .unit_ack(unit_ack), .writeback_suppress(writeback_suppress),
        .commit_valid(commit_valid), .commit_phys_addr(commit_phys_addr),
        .commit_data(commit_data), .commit_unit(commit_unit)
    );

    always #5 clk = ~clk;

    // pack the per-unit stimulus arrays onto the flat buses
    always_comb begin
        unit_phys_addr = '0;
        unit_data      = '0;
        for (int i = 0; i < 4; i++) begin
            unit_phys_addr[i*6 +: 6] = addr_a[i];
            unit_data[i*32 +: 32]    = data_a[i];
        end
    end

    task automatic step(input logic [3:0] v, input logic sup, input logic r, input logic [3:0] exp_ack);
        commit_t e;
        commit_t o;
        unit_valid = v;
        writeback_suppress = sup;
        rst = r;
        #1;
        tests++;
        assert (unit_ack === exp_ack) else begin
            fails++;
            $error("FAIL ack observed=%b expected=%b", unit_ack, exp_ack);
        end
        e = m_hold;
        e.v = 1'b0;
        if (r) e = '0;
        for (int i = 0; i < 4; i++)
            if (exp_ack[i]) begin
                e.a = addr_a[i];
                e.d = data_a[i];
                e.u = 2'(i);
                e.v = (addr_a[i] != 6'd0);
            end
        m_hold = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        o = '{v: commit_valid, a: commit_phys_addr, d: commit_data, u: commit_unit};
        tests++;
        assert (o.v === e.v) else begin
            fails++;
            $error("FAIL commit_valid observed=%b expected=%b", o.v, e.v);
        end
        tests++;
        assert (o.a === e.a) else begin
            fails++;
            $error("FAIL commit_phys_addr observed=%0d expected=%0d", o.a, e.a);
        end
        tests++;
        assert (o.d === e.d) else begin
            fails++;
            $error("FAIL commit_data observed=%h expected=%h", o.d, e.d);
        end
        tests++;
        assert (o.u === e.u) else begin
            fails++;
            $error("FAIL commit_unit observed=%0d expected=%0d", o.u, e.u);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            addr_a[i] = 6'(10 + i);
            data_a[i] = 32'hA000_0000 + 32'(i * 17);
        end
        @(posedge clk);
        #1;
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        step(4'b1111, 1'b0, 1'b1, 4'b0000);
        addr_a[0] = 6'd5;
        data_a[0] = 32'hDEAD_BEEF;
        step(4'b0001, 1'b0, 1'b0, 4'b0001);
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        addr_a[0] = 6'd10;
        data_a[0] = 32'h1111_0000;
        for (int n = 0; n < 8; n++) step(4'b1111, 1'b0, 1'b0, 4'(1 << (n % 4)));
        step(4'b0010, 1'b0, 1'b0, 4'b0010);
        step(4'b0011, 1'b0, 1'b0, 4'b0001);
        step(4'b0010, 1'b0, 1'b0, 4'b0010);
        addr_a[2] = 6'd0;
        data_a[2] = 32'h0000_1234;
        step(4'b0100, 1'b0, 1'b0, 4'b0100);
        addr_a[2] = 6'd12;
        data_a[2] = 32'hCAFE_0002;
        step(4'b1000, 1'b0, 1'b0, 4'b1000);
        for (int n = 0; n < 3; n++) step(4'b1010, 1'b1, 1'b0, 4'b0000);
        step(4'b1010, 1'b0, 1'b0, 4'b0010);
        step(4'b1000, 1'b0, 1'b0, 4'b1000);
        addr_a[1] = 6'd63;
        data_a[1] = 32'h5A5A_A5A5;
        step(4'b0010, 1'b0, 1'b0, 4'b0010);
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        step(4'b1111, 1'b0, 1'b0, 4'b0001);
        step(4'b0100, 1'b0, 1'b0, 4'b0100);
        step(4'b0100, 1'b0, 1'b0, 4'b0100);
        step(4'b0000, 1'b0, 1'b0, 4'b0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
